power_sweep_ctrl: RTL and testbench

POWER_SWEEP_CTRL -- requirements
Module: power_sweep_ctrl

---
 rtl/power_sweep_pkg.sv | 21 ++
 rtl/power_sweep_gray.sv | 11 +
 rtl/power_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_power_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power_sweep_pkg.sv
// Shared types and sizing for the exhaustive 4-input cell sweep controller.
// The FSM encoding, pattern count and counter widths all come from here.
package power_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int PATTERN_CNT = 16;
  localparam int LAST_IDX    = PATTERN_CNT - 1;
  localparam int IDX_W       = 4;
  localparam int VEC_W       = 4;
  localparam int ONES_W      = 5;
  localparam int TOGGLE_W    = 5;
  localparam int SETTLE_W    = 4;
  localparam int MASK_W      = PATTERN_CNT;

endpackage

// File: rtl/power_sweep_gray.sv
// Combinational 4-bit binary to reflected Gray code converter.
module power_sweep_gray
  import power_sweep_pkg::*;
(
  input  logic [IDX_W-1:0] bin,
  output logic [IDX_W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/power_sweep_ctrl.sv
// Walks all 16 input patterns of an external 4-input cell, holds each for
// SETTLE_CYC cycles, samples the cell output and accumulates response statistics.
module power_sweep_ctrl
  import power_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  output logic [VEC_W-1:0]    vec_out,
  input  logic                cell_in,
  output logic                busy,
  output logic                done,
  output logic                result_valid,
  output logic [ONES_W-1:0]   ones_cnt,
  output logic [TOGGLE_W-1:0] toggle_cnt,
  output logic [MASK_W-1:0]   resp_mask
);

  sweep_state_t         state;
  sweep_state_t         state_next;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     gray_idx;
  logic [IDX_W-1:0]     pattern;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 mode_lat;
  logic                 prev_sample;
  logic                 settle_last;
  logic                 idx_last;

  power_sweep_gray u_gray (
    .bin  (idx),
    .gray (gray_idx)
  );

  assign pattern     = mode_lat ? gray_idx : idx;
  assign settle_last = (settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
  assign idx_last    = (idx == IDX_W'(LAST_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides everything, including a simultaneous start in IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    vec_out    = '0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy    = 1'b1;
        vec_out = pattern;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (settle_last) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        busy    = 1'b1;
        vec_out = pattern;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (idx_last) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      settle_cnt   <= '0;
      mode_lat     <= 1'b0;
      prev_sample  <= 1'b0;
      result_valid <= 1'b0;
      ones_cnt     <= '0;
      toggle_cnt   <= '0;
      resp_mask    <= '0;
    end else if (abort) begin
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx          <= '0;
            settle_cnt   <= '0;
            mode_lat     <= mode;
            prev_sample  <= 1'b0;
            result_valid <= 1'b0;
            ones_cnt     <= '0;
            toggle_cnt   <= '0;
            resp_mask    <= '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + SETTLE_W'(1);
        end
        ST_SAMPLE: begin
          // Results become valid together with the done pulse.
          resp_mask[pattern] <= cell_in;
          prev_sample        <= cell_in;
          if (cell_in) begin
            ones_cnt <= ones_cnt + ONES_W'(1);
          end
          if ((idx != '0) && (cell_in != prev_sample)) begin
            toggle_cnt <= toggle_cnt + TOGGLE_W'(1);
          end
          if (idx_last) begin
            result_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_sweep_ctrl.sv
// Scoreboard bench: two sweepers (SETTLE_CYC 1 and 3) share stimulus, each drives
// its own copy of the cell n_1&n_3 | n_2&(n_1^(n_3&n_4)).
module tb_power_sweep_ctrl;

  typedef struct {
    logic [4:0]  ones;
    logic [4:0]  tog;
    logic [15:0] mask;
    int          lat;
    int          start_cyc;
  } exp_t;

  localparam logic [3:0] GRAY_SEQ [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  logic clk = 1'b0;
  logic rst_n, start, abort, mode;
  logic [3:0]  vec1, vec3;
  logic        cell1, cell3;
  logic        busy1, busy3, done1, done3, rv1, rv3;
  logic [4:0]  ones1, ones3, tog1, tog3;
  logic [15:0] mask1, mask3;

  exp_t q1[$];
  exp_t q3[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic cur_mode = 1'b0;
  int   active[2];
  int   kidx[2];
  int   run[2];
  logic [3:0] last_vec[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic cell_fn(input logic [3:0] v);
    return (v[0] & v[2]) | (v[1] & (v[0] ^ (v[2] & v[3])));
  endfunction

  assign cell1 = cell_fn(vec1);
  assign cell3 = cell_fn(vec3);

  power_sweep_ctrl #(.SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .vec_out(vec1), .cell_in(cell1), .busy(busy1), .done(done1),
    .result_valid(rv1), .ones_cnt(ones1), .toggle_cnt(tog1), .resp_mask(mask1)
  );

  power_sweep_ctrl #(.SETTLE_CYC(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .vec_out(vec3), .cell_in(cell3), .busy(busy3), .done(done3),
    .result_valid(rv3), .ones_cnt(ones3), .toggle_cnt(tog3), .resp_mask(mask3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic trackVec(input int i, input int s, input logic b, input logic [3:0] v);
    logic [3:0] ev;
    string tag = (i == 0) ? "s1" : "s3";
    if (!b) begin
      checkOutput({tag, "_vec_idle"}, 32'(v), 32'd0);
      active[i] = 0;
    end else if (active[i] == 0) begin
      active[i]   = 1;
      kidx[i]     = 0;
      run[i]      = 1;
      last_vec[i] = v;
      checkOutput({tag, "_vec_first"}, 32'(v), 32'd0);
    end else if (v == last_vec[i]) begin
      run[i]++;
    end else begin
      checkOutput({tag, "_hold"}, 32'(run[i]), 32'(s + 1));
      kidx[i]++;
      ev = (kidx[i] > 15) ? 4'hx : (cur_mode ? GRAY_SEQ[kidx[i]] : 4'(kidx[i]));
      checkOutput({tag, "_vec_seq"}, 32'(v), 32'(ev));
      last_vec[i] = v;
      run[i]      = 1;
    end
  endtask

  task automatic checkDone(input int i, input logic [4:0] o, input logic [4:0] t,
                           input logic [15:0] m, input logic rv, input logic b);
    exp_t e;
    string tag = (i == 0) ? "s1" : "s3";
    if ((i == 0 && q1.size() == 0) || (i == 1 && q3.size() == 0)) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_unexpected_done: got done=1 required done=0 (t=%0t)", tag, $time);
      return;
    end
    if (i == 0) e = q1.pop_front();
    else        e = q3.pop_front();
    checkOutput({tag, "_ones"},    32'(o),  32'(e.ones));
    checkOutput({tag, "_toggles"}, 32'(t),  32'(e.tog));
    checkOutput({tag, "_mask"},    32'(m),  32'(e.mask));
    checkOutput({tag, "_rv_at_done"}, 32'(rv), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(b), 32'd0);
    checkOutput({tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
  endtask

  // Monitor: pops the scoreboard whenever a done pulse is seen.
  always @(negedge clk) begin
    trackVec(0, 1, busy1, vec1);
    trackVec(1, 3, busy3, vec3);
    if (done1) checkDone(0, ones1, tog1, mask1, rv1, busy1);
    if (done3) checkDone(1, ones3, tog3, mask3, rv3, busy3);
  end

  task automatic applyStimulus(input logic m, input logic push, input logic [4:0] eo,
                               input logic [4:0] et, input logic [15:0] em);
    exp_t e;
    start    = 1'b1;
    mode     = m;
    cur_mode = m;
    if (push) begin
      e.ones = eo; e.tog = et; e.mask = em; e.start_cyc = cyc;
      e.lat = 33; q1.push_back(e);
      e.lat = 65; q3.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic waitSweep(input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (q1.size() == 0 && q3.size() == 0) break;
    end
    if (q1.size() != 0 || q3.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL sweep_timeout: got pending=%0d required pending=0", q1.size() + q3.size());
      q1.delete();
      q3.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"}, 32'({busy1, busy3}), 32'd0);
    checkOutput({name, "_done"}, 32'({done1, done3}), 32'd0);
    checkOutput({name, "_rv"},   32'({rv1, rv3}),     32'd0);
    checkOutput({name, "_vec"},  32'({vec1, vec3}),   32'd0);
    checkOutput({name, "_ones"}, 32'({ones1, ones3}), 32'd0);
    checkOutput({name, "_tog"},  32'({tog1, tog3}),   32'd0);
    checkOutput({name, "_mask1"}, 32'(mask1), 32'd0);
    checkOutput({name, "_mask3"}, 32'(mask3), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    active = '{0, 0};
    kidx   = '{0, 0};
    run    = '{0, 0};
    last_vec = '{4'd0, 4'd0};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] binary sweep");
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd9, 16'hE8A8);
    waitSweep(200);
    repeat (3) @(negedge clk);
    checkOutput("rv_hold", 32'({rv1, rv3}), 32'd3);
    checkOutput("mask_hold", 32'(mask1), 32'hE8A8);

    $display("[TB] gray sweep with ignored restart");
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd8, 16'hE8A8);
    repeat (5) @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waitSweep(200);

    $display("[TB] abort at cycle 10");
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'({busy1, busy3}), 32'd0);
    checkOutput("abort_rv",   32'({rv1, rv3}),     32'd0);
    checkOutput("abort_s1_ones", 32'(ones1), 32'd1);
    checkOutput("abort_s1_tog",  32'(tog1),  32'd1);
    checkOutput("abort_s1_mask", 32'(mask1), 32'h0008);
    checkOutput("abort_s3_ones", 32'(ones3), 32'd0);
    checkOutput("abort_s3_mask", 32'(mask3), 32'h0000);
    repeat (80) @(negedge clk);
    checkOutput("abort_stays_idle", 32'({busy1, busy3}), 32'd0);

    $display("[TB] sweep after abort");
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd9, 16'hE8A8);
    waitSweep(200);

    $display("[TB] start with abort in idle");
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", 32'({busy1, busy3}), 32'd0);
    checkOutput("start_abort_rv",   32'({rv1, rv3}),     32'd0);
    checkOutput("start_abort_mask", 32'(mask1), 32'hE8A8);
    repeat (3) @(negedge clk);
    checkOutput("start_abort_idle", 32'({busy1, busy3}), 32'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 16'h0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkAllZero("post_reset");

    $display("[TB] sweep after reset");
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd9, 16'hE8A8);
    waitSweep(200);

    checkOutput("leftover", 32'(q1.size() + q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
